// File: rtl/udp_pkt_sync_fifo.sv
// Single-clock FIFO between the UDP checksum stage and the MAC TX framer.
// In packet mode, frames are written speculatively and become readable only once committed.
module udp_pkt_sync_fifo #(
  parameter int DATA_WIDTH       = 32,
  parameter int DEPTH_WIDTH      = 8,
  parameter int ALMOST_FULL_NUM  = 250,
  parameter int ALMOST_EMPTY_NUM = 4,
  parameter int PKT_MODE         = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  input  logic                  wr_drop,
  output logic                  wr_full,
  output logic                  almost_full,
  output logic [DEPTH_WIDTH:0]  wr_water_level,
  output logic                  wr_ovf,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_empty,
  output logic                  almost_empty,
  output logic [DEPTH_WIDTH:0]  rd_water_level,
  output logic [DEPTH_WIDTH:0]  rd_pkt_cnt
);

  localparam int PW    = DEPTH_WIDTH + 1;
  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [PW-1:0] FULL_LVL = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [31:0]   AF_NUM   = ALMOST_FULL_NUM;
  localparam logic [31:0]   AE_NUM   = ALMOST_EMPTY_NUM;
  localparam bit            PKT      = (PKT_MODE != 0);

  logic [DATA_WIDTH:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] cm_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] pkt_cnt;
  logic [PW-1:0] wr_ptr_nxt;
  logic          err;
  logic          drop_req;
  logic          wr_acc;
  logic          rd_acc;
  logic          commit;
  logic          rd_word_last;
  logic          pkt_dec;

  assign wr_water_level = wr_ptr - rd_ptr;
  assign rd_water_level = cm_ptr - rd_ptr;
  assign wr_full        = (wr_water_level == FULL_LVL);
  assign rd_empty       = (rd_water_level == '0);
  assign almost_full    = (32'(wr_water_level) >= AF_NUM);
  assign almost_empty   = (32'(rd_water_level) <= AE_NUM);
  assign rd_pkt_cnt     = pkt_cnt;

  assign wr_ptr_nxt   = wr_ptr + 1'b1;
  assign drop_req     = PKT && wr_drop;
  assign wr_acc       = wr_en && !wr_full && !drop_req;
  assign rd_acc       = rd_en && !rd_empty;
  assign commit       = PKT && wr_acc && wr_last && !err;
  assign rd_word_last = mem[rd_ptr[DEPTH_WIDTH-1:0]][DATA_WIDTH];
  assign pkt_dec      = PKT && rd_acc && rd_word_last;

  // Write stage: storage is never reset, only the pointers guarding it.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[DEPTH_WIDTH-1:0]] <= {wr_last, wr_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      cm_ptr <= '0;
      err    <= 1'b0;
      wr_ovf <= 1'b0;
    end else begin
      wr_ovf <= wr_en && wr_full && !drop_req;
      if (drop_req) begin
        wr_ptr <= cm_ptr;
        err    <= 1'b0;
      end else if (wr_acc) begin
        // A frame that lost words to overflow is discarded when its last word arrives.
        if (PKT && wr_last && err) begin
          wr_ptr <= cm_ptr;
          err    <= 1'b0;
        end else begin
          wr_ptr <= wr_ptr_nxt;
        end
        if (!PKT || commit) cm_ptr <= wr_ptr_nxt;
      end else if (PKT && wr_en && wr_full) begin
        err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else begin
      case ({commit, pkt_dec})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // Read stage: one cycle from rd_en to rd_data; output holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      rd_data <= '0;
      rd_last <= 1'b0;
    end else if (rd_acc) begin
      rd_ptr  <= rd_ptr + 1'b1;
      rd_data <= mem[rd_ptr[DEPTH_WIDTH-1:0]][DATA_WIDTH-1:0];
      rd_last <= PKT && rd_word_last;
    end
  end

endmodule

// File: doc/udp_pkt_sync_fifo.md
Name: udp_pkt_sync_fifo

Overview:
Parametrised single-clock FIFO for the UDP/IP datapath. It generalises the fixed 32x256 checksum FIFO with configurable width and depth, and adds a packet mode with frame commit/drop. In packet mode the UDP builder streams a payload in, then either commits it (once the checksum is known) or discards it, and the reader only ever sees committed whole frames. It sits between the checksum calculator and the MAC TX framer.

Parameters:
DATA_WIDTH, 32, payload width per entry (1..1152)
DEPTH_WIDTH, 8, log2 of entry count; depth = 2^DEPTH_WIDTH (4..16)
ALMOST_FULL_NUM, 250, almost_full asserts when wr_water_level >= this value
ALMOST_EMPTY_NUM, 4, almost_empty asserts when rd_water_level <= this value
PKT_MODE, 1, 1 = frame commit/drop enabled; 0 = plain FIFO

Ports:
clk  in  1  single clock for all logic
rst  in  1  synchronous reset, active-high
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write data
wr_last  in  1  marks last word of a frame (PKT_MODE=1)
wr_drop  in  1  discard the uncommitted frame (PKT_MODE=1)
wr_full  out  1  no free entry
almost_full  out  1  write-side threshold flag
wr_water_level  out  DEPTH_WIDTH+1  entries used, including uncommitted words
wr_ovf  out  1  one-cycle pulse when a write is rejected because the FIFO is full
rd_en  in  1  read request
rd_data  out  DATA_WIDTH  read data
rd_last  out  1  last flag of the word on rd_data
rd_empty  out  1  no committed entry available
almost_empty  out  1  read-side threshold flag
rd_water_level  out  DEPTH_WIDTH+1  committed entries not yet read
rd_pkt_cnt  out  DEPTH_WIDTH+1  committed frames not yet fully read

Behaviour:
- Clocking and reset: one clock, rst synchronous active-high. All state updates on the rising edge of clk.
- Storage: 2^DEPTH_WIDTH x (DATA_WIDTH+1) RAM; the extra bit is the last flag.
- Pointers: wr_ptr (speculative), cm_ptr (committed) and rd_ptr, each DEPTH_WIDTH+1 bits, wrap modulo 2^(DEPTH_WIDTH+1).
- Level decodes:
  - wr_water_level = wr_ptr - rd_ptr; wr_full = (wr_water_level == 2^DEPTH_WIDTH).
  - rd_water_level = cm_ptr - rd_ptr; rd_empty = (rd_water_level == 0).
  - Flags are decoded from registered state with no extra latency.
- Write acceptance: a write is accepted iff wr_en && !wr_full && !wr_drop, evaluated on start-of-cycle state. A simultaneous read does not free a slot for the same-cycle write.
- Accepted write: RAM[wr_ptr] <= {wr_last, wr_data}; wr_ptr += 1.
- Rejected write: wr_en && wr_full -> wr_ovf = 1 for one cycle, nothing stored. In PKT_MODE=1 this also sets the sticky err flag.
- Commit (PKT_MODE=1): an accepted write with wr_last=1 and err=0 sets cm_ptr <= wr_ptr+1 and rd_pkt_cnt += 1. rd_empty can deassert the next cycle.
- Auto-drop: an accepted write with wr_last=1 and err=1 sets wr_ptr <= cm_ptr (the frame is discarded, including this word) and clears err.
- Explicit drop: wr_drop=1 sets wr_ptr <= cm_ptr and clears err; a same-cycle wr_en is ignored. A drop with no uncommitted data is a no-op.
- PKT_MODE=0: cm_ptr follows every accepted write; wr_last is stored but not acted on; wr_drop is ignored; err is never set; rd_pkt_cnt stays 0.
- Read acceptance: a read is accepted iff rd_en && !rd_empty, evaluated on start-of-cycle state. A same-cycle commit does not make an empty FIFO readable.
- Accepted read: rd_ptr += 1; {rd_last, rd_data} <= RAM[rd_ptr], visible the cycle after rd_en (1-cycle latency). rd_data and rd_last hold their value when no read is accepted.
- rd_pkt_cnt: decrements on an accepted read of a word whose last flag is 1. A same-cycle increment and decrement leave it unchanged. rd_last is gated to 0 when PKT_MODE=0.
- Thresholds: almost_full = (wr_water_level >= ALMOST_FULL_NUM); almost_empty = (rd_water_level <= ALMOST_EMPTY_NUM).
- Reset values: all pointers, err and rd_pkt_cnt = 0; rd_data = 0; rd_last = 0; rd_empty = 1; almost_empty = 1; wr_full = 0; almost_full = 0 (for ALMOST_FULL_NUM > 0); wr_ovf = 0; both water levels = 0. RAM contents are not cleared.
- Reset mid-frame: the uncommitted frame and all stored data are lost; no partial frame is ever exposed to the reader.
- Wrap-around: full and empty are distinguished by the pointer MSB. Operation must be continuous across pointer wrap with no bubble.

Test Plan:
- Plain mode (PKT_MODE=0, DEPTH_WIDTH=4): write 0x00..0x0F -> wr_full=1 after the 16th write; a 17th write gives wr_ovf=1. Read 16 words -> data 0x00..0x0F in order, each one cycle after rd_en; rd_empty=1 after the last read.
- Commit (PKT_MODE=1): write 5 words, wr_last on the 5th -> rd_empty stays 1 for words 1-4 and falls the cycle after the 5th; rd_water_level=5, rd_pkt_cnt=1; reading the 5th word gives rd_last=1 and rd_pkt_cnt returns to 0.
- Explicit drop: commit frame A (3 words), write 4 words of frame B, assert wr_drop -> wr_water_level falls from 7 to 3; read returns A only; rd_pkt_cnt goes 1 -> 0.
- Overflow auto-drop (DEPTH_WIDTH=4): with 10 committed words present, write 8 words of a new frame -> 2 rejected with wr_ovf pulses. Read 2 words, then write the last word with wr_last=1 -> frame dropped, wr_water_level=8, rd_pkt_cnt unchanged.
- Simultaneous operation: stream writes and reads concurrently for 40 words across pointer wrap -> no loss or reorder; almost_full=1 exactly when wr_water_level >= ALMOST_FULL_NUM (set to 12); almost_empty toggles at the rd_water_level 4/5 boundary.
- Reset mid-frame: assert rst during an uncommitted 3-word write -> the next cycle shows rd_empty=1, both water levels 0, rd_pkt_cnt=0, wr_full=0.
